// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a two-flop input synchroniser.
// Each bit is sampled at its centre; received bytes are reported as one-cycle strobes.
module uart_rx #(
    parameter int COUNTER_VAL = 104
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(COUNTER_VAL);
    localparam logic [CW-1:0] CNT_MAX = CW'(COUNTER_VAL - 1);
    // Preloading to N-N/2 makes the first tick fall half a bit after the start edge
    localparam logic [CW-1:0] CNT_PRE = CW'(COUNTER_VAL - COUNTER_VAL / 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_meta;
    logic          rx_s;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_out  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                        cnt   <= CNT_PRE;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            data_out <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames plus random traffic,
// compared every cycle against a timing-offset model of the receiver.
module tb_uart_rx;

    localparam int N = 104;
    localparam int H = N / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    always #50 clk = ~clk;

    uart_rx #(.COUNTER_VAL(N)) dut (
        .clk_in   (clk),
        .rst      (rst),
        .rx       (rx),
        .data_out (data_out),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: once the synchronised line is seen low at cycle t0, the frame is
    // read at t0+H (start), t0+H+i*N (data bits), t0+H+9N (stop).
    bit         m1 = 1'b1;
    bit         m2 = 1'b1;
    bit         m_busy = 1'b0;
    int         t0 = 0;
    logic [7:0] m_bits = 8'h00;
    logic [7:0] e_data = 8'h00;
    bit         e_valid = 1'b0;
    bit         e_err = 1'b0;
    bit         started = 1'b0;
    int         n_evalid = 0;
    int         n_eerr = 0;

    always @(posedge clk) begin
        bit rs;
        int k;
        int j;
        cyc++;
        started = 1'b1;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (rst) begin
            m1     = 1'b1;
            m2     = 1'b1;
            m_busy = 1'b0;
            e_data = 8'h00;
        end else begin
            rs = m2;
            m2 = m1;
            m1 = rx;
            if (!m_busy) begin
                if (!rs) begin
                    m_busy = 1'b1;
                    t0     = cyc;
                end
            end else begin
                k = cyc - t0;
                if (k == H) begin
                    if (rs) m_busy = 1'b0;
                end else if (k > H && (k - H) % N == 0) begin
                    j = (k - H) / N;
                    if (j <= 8) begin
                        m_bits[j-1] = rs;
                    end else begin
                        if (rs) begin
                            e_data  = m_bits;
                            e_valid = 1'b1;
                            n_evalid++;
                        end else begin
                            e_err = 1'b1;
                            n_eerr++;
                        end
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    int n_valid = 0;
    int n_err = 0;
    int busy_cnt = 0;
    int last_valid = 0;
    int prev_valid = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    int printed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (printed < 30) begin
                printed++;
                $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("data_out", 32'(data_out), 32'(e_data));
            check("rx_valid", 32'(rx_valid), 32'(e_valid));
            check("frame_err", 32'(frame_err), 32'(e_err));
            check("busy", 32'(busy), 32'(m_busy));
            if (rx_valid === 1'b1) begin
                n_valid++;
                prev_valid = last_valid;
                last_valid = cyc;
                prev_data  = last_data;
                last_data  = data_out;
            end
            if (frame_err === 1'b1) n_err++;
            if (busy === 1'b1) busy_cnt++;
        end
    end

    task automatic hold(input bit v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit stop);
        hold(1'b0, N);
        for (int i = 0; i < 8; i++) hold(d[i], N);
        hold(stop, N);
    endtask

    int v0, e0, b0, dc;
    logic [7:0] rd;

    initial begin
        repeat (3) @(negedge clk);
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset busy", 32'(busy), 32'h0);
        check("reset strobes", 32'({rx_valid, frame_err}), 32'h0);
        rst = 1'b0;
        hold(1'b1, 200);
        check("idle no strobe", 32'(n_valid + n_err), 32'h0);

        // 2 sync stages + edge-to-T0 + H + 9N, strobe one cycle later: 3+52+936 = 991
        dc = cyc;
        send(8'hA5, 1'b1);
        check("A5 strobe time", 32'(last_valid - dc), 32'd991);
        check("A5 data", 32'(data_out), 32'hA5);
        check("A5 count", 32'(n_valid), 32'd1);

        v0 = n_valid;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        check("b2b count", 32'(n_valid - v0), 32'd2);
        check("b2b spacing", 32'(last_valid - prev_valid), 32'd1040);
        check("b2b first", 32'(prev_data), 32'h00);
        check("b2b second", 32'(last_data), 32'hFF);

        hold(1'b1, 50);
        v0 = n_valid; e0 = n_err; b0 = busy_cnt;
        hold(1'b0, 30);
        hold(1'b1, 200);
        check("glitch busy cycles", 32'(busy_cnt - b0), 32'd52);
        check("glitch no strobe", 32'((n_valid - v0) + (n_err - e0)), 32'h0);

        v0 = n_valid; e0 = n_err;
        send(8'h3C, 1'b0);
        hold(1'b1, 20);
        check("ferr count", 32'(n_err - e0), 32'd1);
        check("ferr no valid", 32'(n_valid - v0), 32'd0);
        check("ferr data kept", 32'(data_out), 32'hFF);

        v0 = n_valid;
        hold(1'b0, N);
        rd = 8'h55;
        for (int i = 0; i < 4; i++) hold(rd[i], N);
        hold(rd[4], H);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 1200);
        check("abort no valid", 32'(n_valid - v0), 32'd0);
        check("abort data clr", 32'(data_out), 32'h00);
        send(8'h81, 1'b1);
        hold(1'b1, 10);
        check("after abort count", 32'(n_valid - v0), 32'd1);
        check("after abort data", 32'(data_out), 32'h81);

        for (int it = 0; it < 25; it++) begin
            rd = 8'($urandom);
            send(rd, $urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) hold(1'b0, $urandom_range(5, 60));
            if ($urandom_range(0, 2) != 0) hold(1'b1, $urandom_range(1, 300));
        end

        e0 = n_err;
        hold(1'b0, 2200);
        hold(1'b1, 1200);
        check("break repeats", 32'(n_err - e0 >= 2), 32'd1);
        check("total valid", 32'(n_valid), 32'(n_evalid));
        check("total ferr", 32'(n_err), 32'(n_eerr));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
